// File: rtl/pulse_stretcher.sv
// pulse_stretcher: per-channel edge-triggered pulse stretcher.
// A rising edge on a channel input produces an output pulse that is high for
// exactly 2^ON_CNT_WIDTH cycles. After the pulse, the output is held low for
// at least 2^OFF_CNT_WIDTH cycles (the guard time).
// Optional feature macro: PULSE_STRETCHER_PENDING_EN. When it is defined, an
// event that arrives while a channel is busy is remembered in a one-bit flag,
// and another pulse follows directly after the guard time.
module pulse_stretcher #(
   parameter int WIDTH         = 1,
   parameter int ON_CNT_WIDTH  = 4,
   parameter int OFF_CNT_WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] iv_input,
   output logic [WIDTH-1:0] ov_output,
   output logic [WIDTH-1:0] ov_busy
);

   localparam int CNT_WIDTH = (ON_CNT_WIDTH > OFF_CNT_WIDTH) ? ON_CNT_WIDTH : OFF_CNT_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ON    = 2'd1,
      ST_GUARD = 2'd2
   } state_t;

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      state_t               state_q;
      state_t               state_d;
      logic [CNT_WIDTH-1:0] cnt_q;
      logic [CNT_WIDTH-1:0] cnt_d;
      logic                 prev_q;
      logic                 out_q;
      logic                 event_w;
      logic                 on_done;
      logic                 off_done;
`ifdef PULSE_STRETCHER_PENDING_EN
      logic                 pending_q;
      logic                 pending_d;
`endif

      assign event_w  = iv_input[g] & ~prev_q;
      assign on_done  = &cnt_q[ON_CNT_WIDTH-1:0];
      assign off_done = &cnt_q[OFF_CNT_WIDTH-1:0];

      // Next-state logic. The terminal count always forces a state change,
      // so the counter never wraps.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
`ifdef PULSE_STRETCHER_PENDING_EN
         pending_d = pending_q;
`endif
         case (state_q)
            ST_IDLE: begin
               if (event_w) begin
                  state_d = ST_ON;
                  cnt_d   = '0;
               end
            end
            ST_ON: begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
`ifdef PULSE_STRETCHER_PENDING_EN
               if (event_w) pending_d = 1'b1;
`endif
               if (on_done) begin
                  state_d = ST_GUARD;
                  cnt_d   = '0;
               end
            end
            ST_GUARD: begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
`ifdef PULSE_STRETCHER_PENDING_EN
               if (event_w) pending_d = 1'b1;
               if (off_done) begin
                  cnt_d = '0;
                  if (pending_q || event_w) begin
                     state_d   = ST_ON;
                     pending_d = 1'b0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
`else
               if (off_done) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
`endif
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      // State, counter, input history and registered output. Reset clears
      // everything at once, which cuts off any pulse that is in progress.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            out_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= iv_input[g];
            out_q   <= (state_d == ST_ON);
         end
      end

`ifdef PULSE_STRETCHER_PENDING_EN
      // Pending flag: several events during one busy period count as one.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) pending_q <= 1'b0;
         else          pending_q <= pending_d;
      end
`endif

      assign ov_output[g] = out_q;
      assign ov_busy[g]   = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed checks of pulse_stretcher with
// WIDTH=2, ON_CNT_WIDTH=3 (8-cycle pulse) and OFF_CNT_WIDTH=2 (4-cycle guard).
module tb_pulse_stretcher;

   logic       i_clk;
   logic       i_rst_n;
   logic [1:0] iv_input;
   logic [1:0] ov_output;
   logic [1:0] ov_busy;

   int vec_count;
   int err_count;

   pulse_stretcher #(
      .WIDTH(2),
      .ON_CNT_WIDTH(3),
      .OFF_CNT_WIDTH(2)
   ) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .iv_input(iv_input),
      .ov_output(ov_output),
      .ov_busy(ov_busy)
   );

   // Free-running clock with a 10-unit period.
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Step to one time unit after the next rising edge.
   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_gap;
      iv_input = 2'b00;
      for (int i = 0; i < 20; i++) tick();
   endtask

   // Reset values, and a level that is already high at release counts as an edge.
   task automatic test_reset;
      i_rst_n  = 1'b0;
      iv_input = 2'b11;
      #3;
      vec_count++;
      if (ov_output !== 2'b00 || ov_busy !== 2'b00) begin
         $display("[TB] FAIL reset_state out=%b busy=%b expected out=00 busy=00", ov_output, ov_busy);
         err_count++;
      end
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();
      vec_count++;
      if (ov_output !== 2'b11 || ov_busy !== 2'b11) begin
         $display("[TB] FAIL reset_release_level out=%b busy=%b expected out=11 busy=11", ov_output, ov_busy);
         err_count++;
      end
      idle_gap();
   endtask

   // A single-cycle pulse on ch0 gives 8 cycles high, 4 guard cycles, and ch1 stays idle.
   task automatic test_single_pulse;
      logic [1:0] exp_out, exp_busy;
      for (int k = 0; k < 15; k++) begin
         iv_input = (k == 0) ? 2'b01 : 2'b00;
         tick();
         exp_out  = {1'b0, (k < 8)};
         exp_busy = {1'b0, (k < 12)};
         vec_count++;
         if (ov_output !== exp_out || ov_busy !== exp_busy) begin
            $display("[TB] FAIL single_pulse k=%0d out=%b busy=%b expected out=%b busy=%b",
                     k, ov_output, ov_busy, exp_out, exp_busy);
            err_count++;
         end
      end
      idle_gap();
   endtask

   // A long level produces exactly one pulse.
   task automatic test_level;
      logic [1:0] exp_out, exp_busy;
      for (int k = 0; k < 56; k++) begin
         iv_input = (k < 50) ? 2'b01 : 2'b00;
         tick();
         exp_out  = {1'b0, (k < 8)};
         exp_busy = {1'b0, (k < 12)};
         vec_count++;
         if (ov_output !== exp_out || ov_busy !== exp_busy) begin
            $display("[TB] FAIL level_hold k=%0d out=%b busy=%b expected out=%b busy=%b",
                     k, ov_output, ov_busy, exp_out, exp_busy);
            err_count++;
         end
      end
      idle_gap();
   endtask

   // Three events during ON: with the pending flag they coalesce into one extra pulse.
   task automatic test_pending;
      logic [1:0] exp_out, exp_busy;
      for (int k = 0; k < 28; k++) begin
         iv_input = (k == 0 || k == 2 || k == 4) ? 2'b01 : 2'b00;
         tick();
`ifdef PULSE_STRETCHER_PENDING_EN
         exp_out  = {1'b0, (k < 8) || (k >= 12 && k < 20)};
         exp_busy = {1'b0, (k < 24)};
`else
         exp_out  = {1'b0, (k < 8)};
         exp_busy = {1'b0, (k < 12)};
`endif
         vec_count++;
         if (ov_output !== exp_out || ov_busy !== exp_busy) begin
            $display("[TB] FAIL pending_events k=%0d out=%b busy=%b expected out=%b busy=%b",
                     k, ov_output, ov_busy, exp_out, exp_busy);
            err_count++;
         end
      end
      idle_gap();
   endtask

   // An event sampled on the GUARD->IDLE edge is treated as arriving in GUARD.
   task automatic test_back_to_back;
      logic [1:0] exp_out, exp_busy;
      for (int k = 0; k < 28; k++) begin
         iv_input = (k == 0 || k == 12) ? 2'b01 : 2'b00;
         tick();
`ifdef PULSE_STRETCHER_PENDING_EN
         exp_out  = {1'b0, (k < 8) || (k >= 12 && k < 20)};
         exp_busy = {1'b0, (k < 24)};
`else
         exp_out  = {1'b0, (k < 8)};
         exp_busy = {1'b0, (k < 12)};
`endif
         vec_count++;
         if (ov_output !== exp_out || ov_busy !== exp_busy) begin
            $display("[TB] FAIL last_guard_event k=%0d out=%b busy=%b expected out=%b busy=%b",
                     k, ov_output, ov_busy, exp_out, exp_busy);
            err_count++;
         end
      end
      idle_gap();
   endtask

   // Asynchronous reset in the middle of a pulse clears the outputs before any clock edge.
   task automatic test_async_reset;
      for (int k = 0; k < 4; k++) begin
         iv_input = (k == 0) ? 2'b01 : 2'b00;
         tick();
      end
      vec_count++;
      if (ov_output !== 2'b01 || ov_busy !== 2'b01) begin
         $display("[TB] FAIL pre_reset_pulse out=%b busy=%b expected out=01 busy=01", ov_output, ov_busy);
         err_count++;
      end
      #2;
      i_rst_n = 1'b0;
      #1;
      vec_count++;
      if (ov_output !== 2'b00 || ov_busy !== 2'b00) begin
         $display("[TB] FAIL async_reset out=%b busy=%b expected out=00 busy=00", ov_output, ov_busy);
         err_count++;
      end
      tick();
      i_rst_n = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         vec_count++;
         if (ov_output !== 2'b00 || ov_busy !== 2'b00) begin
            $display("[TB] FAIL post_reset_idle k=%0d out=%b busy=%b expected out=00 busy=00",
                     k, ov_output, ov_busy);
            err_count++;
         end
      end
      idle_gap();
   endtask

   // Events on the two channels, five cycles apart, give two independent pulses.
   task automatic test_two_channels;
      logic [1:0] exp_out, exp_busy;
      for (int k = 0; k < 22; k++) begin
         iv_input = {(k == 5), (k == 0)};
         tick();
         exp_out  = {(k >= 5 && k < 13), (k < 8)};
         exp_busy = {(k >= 5 && k < 17), (k < 12)};
         vec_count++;
         if (ov_output !== exp_out || ov_busy !== exp_busy) begin
            $display("[TB] FAIL two_channels k=%0d out=%b busy=%b expected out=%b busy=%b",
                     k, ov_output, ov_busy, exp_out, exp_busy);
            err_count++;
         end
      end
      idle_gap();
   endtask

   // Run the scenarios one after another, then print the summary line.
   initial begin
      vec_count = 0;
      err_count = 0;
      i_rst_n   = 1'b0;
      iv_input  = 2'b00;
      test_reset();
      test_single_pulse();
      test_level();
      test_pending();
      test_back_to_back();
      test_async_reset();
      test_two_channels();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule
